// File: rtl/neuron_mac.sv
// neuron_mac: streams two vectors from mem, signed fixed-point MAC, writes saturated result.
// Optional fused ReLU on the written value when NEURON_MAC_RELU_EN is defined.
module neuron_mac #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int ACC_WIDTH  = 40
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_a,
    input  logic [ADDR_WIDTH-1:0] base_b,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    output logic [ADDR_WIDTH-1:0] read_addr_1,
    output logic [ADDR_WIDTH-1:0] read_addr_2,
    input  logic [DATA_WIDTH-1:0] read_data_1,
    input  logic [DATA_WIDTH-1:0] read_data_2,
    output logic                  write_en,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [ADDR_WIDTH-1:0] r_base_a;
    logic [ADDR_WIDTH-1:0] r_base_b;
    logic [ADDR_WIDTH-1:0] r_dst;
    logic [ADDR_WIDTH:0]   r_len;
    logic [ADDR_WIDTH:0]   r_idx;
    logic                  r_valid;

    logic signed [ACC_WIDTH-1:0]    r_acc;
    logic signed [2*DATA_WIDTH-1:0] w_prod;
    logic signed [ACC_WIDTH-1:0]    w_prod_ext;
    logic signed [ACC_WIDTH-1:0]    w_acc_next;
    logic signed [ACC_WIDTH-1:0]    w_shift;
    logic [ACC_WIDTH-DATA_WIDTH:0]  w_hi;
    logic                           w_fits;
    logic [DATA_WIDTH-1:0]          w_sat;
    logic [DATA_WIDTH-1:0]          w_result;

    // r_idx counts reads already issued; the first is issued on the start edge
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_next = (length == '0) ? S_DRAIN : S_READ;
            S_READ:  if (r_idx == r_len) w_next = S_DRAIN;
            S_DRAIN: w_next = S_WRITE;
            S_WRITE: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_prod     = $signed(read_data_1) * $signed(read_data_2);
        w_prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){w_prod[2*DATA_WIDTH-1]}}, w_prod};
        w_acc_next = r_valid ? r_acc + w_prod_ext : r_acc;
        w_shift    = w_acc_next >>> FRAC_BITS;
        w_hi       = w_shift[ACC_WIDTH-1:DATA_WIDTH-1];
        w_fits     = (&w_hi) | ~(|w_hi);
        if (w_fits)
            w_sat = w_shift[DATA_WIDTH-1:0];
        else if (w_shift[ACC_WIDTH-1])
            w_sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        else
            w_sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
`ifdef NEURON_MAC_RELU_EN
        w_result = w_sat[DATA_WIDTH-1] ? '0 : w_sat;
`else
        w_result = w_sat;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base_a    <= '0;
            r_base_b    <= '0;
            r_dst       <= '0;
            r_len       <= '0;
            r_idx       <= '0;
            r_valid     <= 1'b0;
            r_acc       <= '0;
            read_addr_1 <= '0;
            read_addr_2 <= '0;
            write_en    <= 1'b0;
            write_addr  <= '0;
            write_data  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            busy     <= (w_next != S_IDLE);
            done     <= (w_next == S_DONE);
            write_en <= (w_next == S_WRITE);
            r_valid  <= (r_state == S_READ);
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base_a <= base_a;
                        r_base_b <= base_b;
                        r_len    <= length;
                        r_dst    <= dst_addr;
                        r_acc    <= '0;
                        r_idx    <= '0;
                        if (length != '0) begin
                            read_addr_1 <= base_a;
                            read_addr_2 <= base_b;
                            r_idx       <= 1;
                        end
                    end
                end
                S_READ: begin
                    r_acc <= w_acc_next;
                    if (r_idx != r_len) begin
                        read_addr_1 <= r_base_a + r_idx[ADDR_WIDTH-1:0];
                        read_addr_2 <= r_base_b + r_idx[ADDR_WIDTH-1:0];
                        r_idx       <= r_idx + 1'b1;
                    end
                end
                S_DRAIN: begin
                    r_acc      <= w_acc_next;
                    write_addr <= r_dst;
                    write_data <= w_result;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/neuron_mac.md
# neuron_mac

Dot-product sequencer that sits directly downstream of the dual-read-port `mem` block in the autoencoder datapath. It drives both read ports to stream an input vector and a weight vector and multiplies the pairs in signed fixed point. It accumulates the products, then writes the saturated neuron pre-activation back through the memory's write port. It is the compute stage for one neuron per `start` command.

## Interface
- `ADDR_WIDTH`, 4, memory address width; must match `mem`.
- `DATA_WIDTH`, 16, signed fixed-point word width.
- `FRAC_BITS`, 8, fractional bits of every operand and of the result.
- `ACC_WIDTH`, 40, signed accumulator width; must be ≥ 2*DATA_WIDTH + ADDR_WIDTH.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  command strobe; sampled only in IDLE.
- `base_a`  in  ADDR_WIDTH  first address of vector A (read port 1).
- `base_b`  in  ADDR_WIDTH  first address of vector B (read port 2).
- `length`  in  ADDR_WIDTH+1  element count, 0..2^ADDR_WIDTH.
- `dst_addr`  in  ADDR_WIDTH  result write address.
- `read_addr_1`  out  ADDR_WIDTH  to `mem` read port 1.
- `read_addr_2`  out  ADDR_WIDTH  to `mem` read port 2.
- `read_data_1`  in  DATA_WIDTH  from `mem`; valid at the rising edge after the address is driven.
- `read_data_2`  in  DATA_WIDTH  as above.
- `write_en`  out  1  to `mem`.
- `write_addr`  out  ADDR_WIDTH  to `mem`.
- `write_data`  out  DATA_WIDTH  to `mem`; also the result.
- `busy`  out  1  high while a command is in flight.
- `done`  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, READ, DRAIN, WRITE, DONE.
- IDLE → READ:
  - Transition on `start`=1.
  - `base_a`, `base_b`, `length` and `dst_addr` are latched.
  - The accumulator and the index are cleared.
  - If `length`=0, go IDLE → DRAIN instead, with no reads.
- READ:
  - Each cycle, drive `read_addr_1`=base_a+i and `read_addr_2`=base_b+i, each modulo 2^ADDR_WIDTH (wrap-around).
  - i counts 0..length-1; leave to DRAIN after i=length-1 is issued.
- Accumulation:
  - The read pair issued in cycle k is multiplied in cycle k+1.
  - The full 2*DATA_WIDTH signed product is sign-extended and added to the ACC_WIDTH accumulator.
  - No rounding or saturation is applied during accumulation.
- DRAIN: absorbs the last product; one cycle.
- WRITE:
  - `write_en`=1 for exactly one cycle, with `write_addr`=dst_addr.
  - `write_data` = sat(acc >>> FRAC_BITS), an arithmetic shift (truncation toward −∞).
  - The result saturates to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
- DONE: `done`=1 for one cycle, then return to IDLE.
- `busy`=1 in READ, DRAIN, WRITE and DONE.
- `start` while busy is ignored; no queuing.
- `dst_addr` may overlap either source vector; the write occurs after the last read, so it is legal.
- `write_data` holds the last result in IDLE; `write_en` is 0 outside WRITE.
- `read_addr_*` hold their last value outside READ.

## Timing
- Reset (asynchronous, immediate, including mid-command):
  - FSM goes to IDLE; accumulator and index are cleared.
  - `busy`, `done` and `write_en` become 0.
  - `read_addr_1`, `read_addr_2`, `write_addr` and `write_data` become 0.
  - An aborted command never writes memory.
- Command with `start` sampled at edge 0 and L = `length` ≥ 1:
  - Reads are issued in cycles 1..L.
  - DRAIN occurs in cycle L+1.
  - `write_en` is high in cycle L+2.
  - `done` is high in cycle L+3.
  - The next `start` is accepted at the edge ending cycle L+3 at the earliest, i.e. once the FSM is back in IDLE.
- L=0: DRAIN in cycle 1, WRITE with data 0 in cycle 2, `done` in cycle 3.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `NEURON_MAC_RELU_EN`:
  - Defined: the saturated result is clamped to 0 when negative before the write (fused ReLU).
  - Undefined: the signed saturated value is written unchanged.
  - Timing is identical in both builds.

## Test plan
- Basic dot product, FRAC_BITS=8, `length`=3:
  - A=[0x0100,0x0200,0x0080], B=[0x0100,0x0100,0x0200].
  - Required: `write_data`=0x0400 with `write_en` in cycle 5, `done` in cycle 6, `busy` low afterwards.
- Positive saturation: `length`=4, all elements 0x7F00 → 0x7FFF written.
- Negative result: A=[0xFF00], B=[0x0300].
  - Without `NEURON_MAC_RELU_EN`: 0xFD00 is written.
  - With `NEURON_MAC_RELU_EN`: 0x0000 is written.
- Wrap and zero length:
  - `base_a`=0xE, `length`=4 → `read_addr_1` sequence 0xE, 0xF, 0x0, 0x1.
  - `length`=0 → 0x0000 written in cycle 2 and `done` in cycle 3.
- Reset and busy handling:
  - `rst_n` pulled low in cycle 2 of a `length`=8 command → all outputs 0 immediately, no `write_en` ever; a new `start` after release completes normally.
  - `start` re-asserted while `busy` is ignored.
